// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions: field widths, the FSM state type and
// classification helpers used by the sequential FP operators.
package fp_pkg;

   localparam int          FP_EXP_W  = 8;
   localparam int          FP_MANT_W = 23;
   localparam int          FP_BIAS   = 127;
   localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != '0);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == '0);
   endfunction

   // Subnormals are deliberately folded into zero.
   function automatic logic is_zero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   // {nan, +inf, -inf, +0, -0} describing a result word.
   function automatic logic [4:0] result_flags(input logic [31:0] x);
      return {is_nan(x), is_inf(x) & ~x[31], is_inf(x) & x[31],
              is_zero(x) & ~x[31], is_zero(x) & x[31]};
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: splits an IEEE-754 single into its fields
// and flags nan/inf/zero (subnormal counts as zero).
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0]          x,
   output logic                 nan,
   output logic                 inf,
   output logic                 zero,
   output logic                 sign,
   output logic [FP_EXP_W-1:0]  exp,
   output logic [FP_MANT_W-1:0] mant
);

   assign nan  = is_nan(x);
   assign inf  = is_inf(x);
   assign zero = is_zero(x);
   assign sign = x[31];
   assign exp  = x[30:23];
   assign mant = x[22:0];

endmodule

// File: rtl/float_mult_seq.sv
// Sequential IEEE-754 single multiplier, shift-add over 24/BITS_PER_CYCLE cycles.
// Build option: FLOAT_MULT_SEQ_RNE_EN selects round-to-nearest-even, else truncation.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// MUL   | shift-add of the 24x24 mantissa product
// NORM  | normalize, round, overflow/underflow
// DONE  | out_valid high until out_ready
module float_mult_seq
   import fp_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_mult,
   output logic        NaN,
   output logic        pos_infinite,
   output logic        neg_infinite,
   output logic        pos_zero,
   output logic        neg_zero
);

   localparam int STEPS = 24 / BITS_PER_CYCLE;

   logic                 a_nan, a_inf, a_zero, a_sign;
   logic                 b_nan, b_inf, b_zero, b_sign;
   logic [FP_EXP_W-1:0]  a_exp, b_exp;
   logic [FP_MANT_W-1:0] a_mant, b_mant;

   fp_classify u_cls_a (.x(a), .nan(a_nan), .inf(a_inf), .zero(a_zero),
                        .sign(a_sign), .exp(a_exp), .mant(a_mant));
   fp_classify u_cls_b (.x(b), .nan(b_nan), .inf(b_inf), .zero(b_zero),
                        .sign(b_sign), .exp(b_exp), .mant(b_mant));

   state_t             state;
   logic [47:0]        mcand, prod, partial;
   logic [23:0]        mplier;
   logic [4:0]         cnt;
   logic signed [9:0]  exp_r, exp_pre, exp_fin;
   logic               sign_r, s, special, round_up;
   logic [22:0]        mant_pre;
   logic [23:0]        mant_rnd;
   logic [31:0]        spec_res, norm_res;
   logic [4:0]         flags_r;

   assign s        = a_sign ^ b_sign;
   assign in_ready = (state == IDLE) && !rst;
   assign {NaN, pos_infinite, neg_infinite, pos_zero, neg_zero} = flags_r;

   always_comb begin
      spec_res = '0;
      special  = 1'b1;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
         spec_res = FP_QNAN;
      else if (a_inf || b_inf)
         spec_res = {s, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         spec_res = {s, 31'd0};
      else
         special = 1'b0;
   end

   always_comb begin
      partial = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++)
         if (mplier[k]) partial = partial + (mcand << k);
   end

   always_comb begin
      if (prod[47]) begin
         mant_pre = prod[46:24];
         exp_pre  = exp_r + 10'sd1;
      end else begin
         mant_pre = prod[45:23];
         exp_pre  = exp_r;
      end
   end

`ifdef FLOAT_MULT_SEQ_RNE_EN
   logic guard, sticky;
   always_comb begin
      guard  = prod[47] ? prod[23] : prod[22];
      sticky = prod[47] ? |prod[22:0] : |prod[21:0];
   end
   assign round_up = guard & (sticky | mant_pre[0]);
`else
   assign round_up = 1'b0;
`endif

   // A carry out of rounding leaves the mantissa at zero and bumps the exponent.
   assign mant_rnd = {1'b0, mant_pre} + {23'd0, round_up};
   assign exp_fin  = mant_rnd[23] ? exp_pre + 10'sd1 : exp_pre;

   always_comb begin
      if (exp_fin >= 10'sd255)
         norm_res = {sign_r, 8'hFF, 23'd0};
      else if (exp_fin <= 10'sd0)
         norm_res = {sign_r, 31'd0};
      else
         norm_res = {sign_r, exp_fin[7:0], mant_rnd[22:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         exp_r     <= '0;
         sign_r    <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_mult  <= '0;
         flags_r   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sign_r <= s;
               if (special) begin
                  out_mult  <= spec_res;
                  flags_r   <= result_flags(spec_res);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  mcand  <= {24'd0, 1'b1, a_mant};
                  mplier <= {1'b1, b_mant};
                  prod   <= '0;
                  exp_r  <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp})
                            - $signed(10'(FP_BIAS));
                  cnt    <= 5'(STEPS - 1);
                  state  <= MUL;
               end
            end
            MUL: begin
               prod   <= prod + partial;
               mcand  <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
               if (cnt == 5'd0) state <= NORM;
               else             cnt   <= cnt - 5'd1;
            end
            NORM: begin
               out_mult  <= norm_res;
               flags_r   <= result_flags(norm_res);
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_mult_seq.sv
// Self-checking bench for float_mult_seq: scoreboard of expected products,
// latency, backpressure and mid-operation reset.
module tb_float_mult_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0, b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_mult;
   logic        NaN, pos_infinite, neg_infinite, pos_zero, neg_zero;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

`ifdef FLOAT_MULT_SEQ_RNE_EN
   localparam logic [31:0] TIE_RES = 32'h3FC0_0002;
`else
   localparam logic [31:0] TIE_RES = 32'h3FC0_0001;
`endif

   float_mult_seq #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out_mult(out_mult), .NaN(NaN), .pos_infinite(pos_infinite),
      .neg_infinite(neg_infinite), .pos_zero(pos_zero), .neg_zero(neg_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   function automatic logic [4:0] flags_now();
      return {NaN, pos_infinite, neg_infinite, pos_zero, neg_zero};
   endfunction

   // flags: {NaN, +inf, -inf, +0, -0}
   task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [31:0] er, input logic [4:0] ef, input int elat,
                        input int hold);
      exp_t e;
      int   lat;
      logic [31:0] held;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_; in_valid = 1'b1;
      sb.push_back('{res: er, flg: ef, lat: elat});
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      if (!out_valid) begin
         check({tag, "_timeout"}, 32'(out_valid), 32'd1);
         return;
      end
      check({tag, "_res"}, out_mult, e.res);
      check({tag, "_flags"}, 32'(flags_now()), 32'(e.flg));
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      held = out_mult;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_res"}, out_mult, held);
         check({tag, "_hold_flags"}, 32'(flags_now()), 32'(e.flg));
         check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ov_fall"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_rise"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_mult", out_mult, 32'd0);
      check("rst_flags", 32'(flags_now()), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);

      do_op("basic",    32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000, 26, 0);
      do_op("renorm",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5'b00000, 26, 0);
      do_op("tie",      32'h3F80_0001, 32'h3FC0_0000, TIE_RES,       5'b00000, 26, 0);
      do_op("neg_prod", 32'hC040_0000, 32'h4080_0000, 32'hC140_0000, 5'b00000, 26, 0);
      do_op("inf_x_0",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000, 1, 0);
      do_op("nan_in",   32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000, 1, 0);
      do_op("ovf",      32'hC000_0000, 32'h7F7F_FFFF, 32'hFF80_0000, 5'b00100, 26, 0);
      do_op("ninf",     32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 5'b00100, 1, 0);
      do_op("pinf",     32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 5'b01000, 1, 0);
      do_op("nzero",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 5'b00001, 1, 0);
      do_op("subnorm",  32'h0000_0001, 32'hC000_0000, 32'h8000_0000, 5'b00001, 1, 0);
      do_op("unf",      32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00010, 26, 0);
      do_op("bp",       32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000, 26, 5);

      // Reset in the middle of MUL; out_mult still holds the previous product.
      @(negedge clk);
      a = 32'h4000_0000; b = 32'h4040_0000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_ov", 32'(out_valid), 32'd0);
      check("mid_rst_mult", out_mult, 32'd0);
      check("mid_rst_flags", 32'(flags_now()), 32'd0);
      check("mid_rst_rdy", 32'(in_ready), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      do_op("after_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 5'b00000, 26, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/float_mult_seq.md
# float_mult_seq

Sequential IEEE-754 single-precision multiplier: the inverse operator of the Newton-Raphson divider. It computes q × d, for example to reconstruct or check a quotient against its numerator. Mantissas are multiplied by iterative shift-add over several cycles, with valid/ready handshakes on both sides. It reports the same five result flags as the divider and slots into the FP datapath next to it.

## Interface
- BITS_PER_CYCLE, 1: multiplier bits consumed per MUL cycle; legal values 1, 2, 4.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_mult  output  32  product.
- NaN  output  1  result is NaN.
- pos_infinite  output  1  result is +inf.
- neg_infinite  output  1  result is -inf.
- pos_zero  output  1  result is +0.
- neg_zero  output  1  result is -0.

## Operation
- **States**
  - IDLE: in_ready=1.
  - MUL: shift-add.
  - NORM: normalize and round.
  - DONE: out_valid=1.
- **Transitions**
  - IDLE→MUL on in_valid&&in_ready when neither operand is special.
  - IDLE→DONE directly when an operand is special.
  - MUL→NORM after 24/BITS_PER_CYCLE cycles.
  - NORM→DONE.
  - DONE→IDLE on out_ready.
- **Operand capture:** a and b are registered on acceptance. Later input changes have no effect.
- **Sign:** sign = a[31]^b[31] for every non-NaN result.
- **Special cases, in priority order:**
  - Either operand NaN (exp 255, mantissa ≠0), or inf×0: result 0x7FC00000, NaN=1.
  - inf × finite: signed infinity.
  - zero × finite: signed zero.
- **Subnormal inputs:** exp 0 with nonzero mantissa is treated as signed zero.
- **Mantissa product:** 24×24 with hidden one; 48-bit product register.
- **Exponent:** 10-bit signed sum ea+eb−127.
- **Normalization:** if P[47]=1, mantissa = P[46:24] and exp+1. Otherwise mantissa = P[45:23].
- **Rounding carry:** a carry out of rounding renormalizes (mantissa 0, exp+1).
- **Overflow:** final exp ≥ 255 gives signed infinity.
- **Underflow:** final exp ≤ 0 gives signed zero (no subnormal output).
- **Flags:** exactly one flag or none is set, and flags describe out_mult. A finite nonzero result has all flags 0.
- **Output stability:** out_mult and the flags are registered. They hold stable while out_valid && !out_ready.

## Timing
- **Reset values:** all outputs 0 while rst is high; state=IDLE.
- **in_ready:** equals (state==IDLE) && !rst, so it is 1 from the first clock after reset release.
- **Normal path:** out_valid rises 24/BITS_PER_CYCLE+2 clock edges after the accepting edge, i.e. 26 for BITS_PER_CYCLE=1.
- **Special path:** out_valid rises 1 edge after acceptance.
- **Output handshake:** the edge with out_valid&&out_ready completes the transfer. out_valid falls and in_ready rises after that edge.
- **No overlap:** there is no same-cycle accept/deliver overlap. Throughput is one operation per latency+1 cycles.
- **Reset mid-operation:** rst during MUL, NORM or DONE returns immediately to IDLE with all outputs 0. The pending result is discarded.
- **Input stalls:** in_valid while in_ready=0 is ignored; the source must hold.

## Configuration
- **Macro:** FLOAT_MULT_SEQ_RNE_EN.
- **With the macro defined:** round-to-nearest-even using guard bit and sticky OR of the remaining product bits. A tie rounds to even.
- **Without it:** truncation (round toward zero). Guard and sticky logic is not built.
- **Unaffected:** special-case handling and latency are identical in both builds.

## Structure
- **Shared package `fp_pkg`:**
  - Constants: FP_EXP_W=8, FP_MANT_W=23, FP_BIAS=127, FP_QNAN=32'h7FC00000.
  - State enum: IDLE/MUL/NORM/DONE.
  - Classify helper: is_nan/is_inf/is_zero.
- **Sub-module `fp_classify`:** combinational; one instance per operand. Outputs the nan/inf/zero/sign/exp/mant fields.
- **Top level:** the FSM, shift-add datapath and normalization stay in float_mult_seq.

## Test plan
- **Basic product:** 0x40000000 × 0x40400000 (2.0×3.0), BITS_PER_CYCLE=1 → out_mult=0x40C00000, out_valid 26 edges after accept, all flags 0.
- **Renormalize:** 0x3FC00000 × 0x3FC00000 → 0x40100000. This exercises P[47]=1.
- **Rounding tie:** 0x3F800001 × 0x3FC00000 → 0x3FC00002 with FLOAT_MULT_SEQ_RNE_EN defined; 0x3FC00001 without it.
- **Special cases:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000, NaN=1, latency 1.
  - 0xC0000000 × 0x7F7FFFFF → 0xFF800000, neg_infinite=1.
  - 0x80000000 × 0x40000000 → 0x80000000, neg_zero=1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid → out_mult and flags stable, in_ready=0. Raise out_ready → in_ready=1 the next cycle.
- **Reset mid-MUL:** assert rst at cycle 10 of MUL → outputs 0 immediately. After release the next operation (1.0×1.0 → 0x3F800000) is correct.
